dmem_sized: RTL and testbench

Parametrised data memory for the CPU load/store path, successor to the word-only data RAM. It adds byte, halfword and word accesses with little-endian byte lanes, sign or zero extension on loads, and alignment checking. A request/ready handshake with a configurable wait-state counter lets the core model slower memory. It sits between the execute/memory stage and the RAM array, selected by CS from the address decoder.

---
 rtl/dmem_sized_if.sv | 25 ++
 rtl/dmem_sized.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_sized.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_sized_if.sv
// Load/store bus between the execute/memory stage and the data memory.
// Signal names follow the core-side address decoder and pipeline.
interface dmem_sized_if;
  logic        CS;
  logic        DM_W;
  logic        DM_R;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        misalign;

  modport master (
    output CS, DM_W, DM_R, addr, wdata, size, sign_ext,
    input  rdata, ready, busy, misalign
  );

  modport slave (
    input  CS, DM_W, DM_R, addr, wdata, size, sign_ext,
    output rdata, ready, busy, misalign
  );
endinterface

// File: rtl/dmem_sized.sv
// Byte/half/word data memory with little-endian lanes, load extension,
// alignment checking and a configurable number of wait states per access.
module dmem_sized #(
  parameter int unsigned DEPTH       = 2048,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic         clk,
  input logic         reset,
  dmem_sized_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWait   = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic          store_q, store_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          mis_q, mis_d;

  logic [31:0] mem [DEPTH];

  logic        req;
  logic        misal;
  logic        mem_we;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] word;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v;

  // Upper address bits are deliberately ignored so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^bus.addr[31:AW+2];

  // Store takes priority when both DM_W and DM_R are raised.
  assign req = bus.CS & (bus.DM_W | bus.DM_R);

  // Alignment check on the incoming request.
  always_comb begin
    misal = 1'b1;
    unique case (bus.size)
      2'b00:   misal = 1'b0;
      2'b01:   misal = bus.addr[0];
      2'b10:   misal = |bus.addr[1:0];
      default: misal = 1'b1;
    endcase
  end

  // Lane enables and replicated write data for the captured store.
  always_comb begin
    be    = 4'b1111;
    wlane = wdata_q;
    unique case (size_q)
      2'b00: begin
        be    = 4'b0001 << lane_q;
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = lane_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
    endcase
  end

  // Lane selection and sign/zero extension for loads; words ignore sign_ext.
  always_comb begin
    word   = mem[idx_q];
    byte_v = 8'(word >> {lane_q, 3'b000});
    half_v = 16'(word >> {lane_q[1], 4'b0000});
    load_v = word;
    unique case (size_q)
      2'b00:   load_v = {{24{sext_q & byte_v[7]}}, byte_v};
      2'b01:   load_v = {{16{sext_q & half_v[15]}}, half_v};
      default: load_v = word;
    endcase
  end

  // Request acceptance, wait-state countdown and single-cycle completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sext_d  = sext_q;
    store_d = store_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    mis_d   = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          idx_d   = bus.addr[AW+1:2];
          lane_d  = bus.addr[1:0];
          wdata_d = bus.wdata;
          size_d  = bus.size;
          sext_d  = bus.sign_ext;
          store_d = bus.DM_W;
          err_d   = misal;
          busy_d  = 1'b1;
          if (misal || (WAIT_STATES == 0)) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (err_q) begin
          mis_d   = 1'b1;
          rdata_d = 32'd0;
        end else if (store_q) begin
          mem_we = 1'b1;
        end else begin
          rdata_d = load_v;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and output registers; an in-flight access is dropped on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      sext_q  <= 1'b0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      store_q <= store_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      mis_q   <= mis_d;
    end
  end

  // RAM array with per-lane write enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          mem[idx_q][8*k +: 8] <= wlane[8*k +: 8];
        end
      end
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.misalign = mis_q;

endmodule

// File: tb/tb_dmem_sized.sv
// Bench for dmem_sized: a zero-wait and a three-wait instance, checked every
// cycle against a byte-addressed transaction model plus directed literals.
module tb_dmem_sized;

  localparam int unsigned DEPTH = 2048;
  localparam int NB = DEPTH * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        cs [2];
  logic        dw [2];
  logic        dr [2];
  logic        sx [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [1:0]  sz [2];
  logic [31:0] rd [2];
  logic        rdy [2];
  logic        bsy [2];
  logic        mis [2];

  dmem_sized_if bus0 ();
  dmem_sized_if bus1 ();

  assign bus0.CS = cs[0];  assign bus0.DM_W = dw[0]; assign bus0.DM_R = dr[0];
  assign bus0.addr = ad[0]; assign bus0.wdata = wd[0]; assign bus0.size = sz[0];
  assign bus0.sign_ext = sx[0];
  assign bus1.CS = cs[1];  assign bus1.DM_W = dw[1]; assign bus1.DM_R = dr[1];
  assign bus1.addr = ad[1]; assign bus1.wdata = wd[1]; assign bus1.size = sz[1];
  assign bus1.sign_ext = sx[1];
  assign rd[0] = bus0.rdata; assign rdy[0] = bus0.ready;
  assign bsy[0] = bus0.busy; assign mis[0] = bus0.misalign;
  assign rd[1] = bus1.rdata; assign rdy[1] = bus1.ready;
  assign bsy[1] = bus1.busy; assign mis[1] = bus1.misalign;

  dmem_sized #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (.clk(clk), .reset(rst_n[0]), .bus(bus0));
  dmem_sized #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_dut1 (.clk(clk), .reset(rst_n[1]), .bus(bus1));

  // Transaction model: a request completes 1+W edges after acceptance
  // (1 edge when rejected); memory is a plain byte array.
  logic [7:0]  mb [2][NB];
  int          rem [2];
  logic        e_rdy [2];
  logic        e_busy [2];
  logic        e_mis [2];
  logic [31:0] e_rd [2];
  logic        p_st [2];
  logic        p_err [2];
  logic        p_sx [2];
  logic [31:0] p_ad [2];
  logic [31:0] p_wd [2];
  logic [1:0]  p_sz [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        rem[i] = 0; e_rdy[i] = 1'b0; e_busy[i] = 1'b0; e_mis[i] = 1'b0; e_rd[i] = 32'd0;
      end else begin
        e_rdy[i] = 1'b0;
        e_mis[i] = 1'b0;
        if (rem[i] > 0) begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) begin
            int ba;
            int nbytes;
            logic [31:0] v;
            e_busy[i] = 1'b0;
            e_rdy[i]  = 1'b1;
            ba     = int'(p_ad[i][12:0]);
            nbytes = 1 << p_sz[i];
            if (p_err[i]) begin
              e_mis[i] = 1'b1;
              e_rd[i]  = 32'd0;
            end else if (p_st[i]) begin
              for (int k = 0; k < nbytes; k++) mb[i][ba + k] = p_wd[i][8*k +: 8];
            end else begin
              v = 32'd0;
              for (int k = 0; k < nbytes; k++) v = v | (32'(mb[i][ba + k]) << (8 * k));
              if (nbytes < 4 && p_sx[i] && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
              e_rd[i] = v;
            end
          end
        end else if (cs[i] && (dw[i] || dr[i])) begin
          p_st[i]  = dw[i];
          p_ad[i]  = ad[i];
          p_wd[i]  = wd[i];
          p_sz[i]  = sz[i];
          p_sx[i]  = sx[i];
          p_err[i] = (sz[i] == 2'b11) || (sz[i] == 2'b01 && ad[i][0]) ||
                     (sz[i] == 2'b10 && ad[i][1:0] != 2'b00);
          rem[i]    = p_err[i] ? 1 : 1 + ((i == 0) ? 0 : 3);
          e_busy[i] = 1'b1;
        end
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then step just past the negedge.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        check($sformatf("u%0d_ready_rst", i), 32'(rdy[i]), 32'd0);
        check($sformatf("u%0d_busy_rst", i), 32'(bsy[i]), 32'd0);
        check($sformatf("u%0d_mis_rst", i), 32'(mis[i]), 32'd0);
        check($sformatf("u%0d_rdata_rst", i), rd[i], 32'd0);
      end else begin
        check($sformatf("u%0d_ready", i), 32'(rdy[i]), 32'(e_rdy[i]));
        check($sformatf("u%0d_busy", i), 32'(bsy[i]), 32'(e_busy[i]));
        check($sformatf("u%0d_mis", i), 32'(mis[i]), 32'(e_mis[i]));
        check($sformatf("u%0d_rdata", i), rd[i], e_rd[i]);
      end
    end
    #1;
  endtask

  // One request with literal latency/misalign/rdata expectations. With poke
  // set, a store to the same address is presented during the busy window.
  task automatic req(input int i, input logic w, input logic r, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] s, input logic x,
                     input logic poke, input int lat, input logic emis,
                     input logic chk, input logic [31:0] erd);
    logic got;
    cs[i] = 1'b1; dw[i] = w; dr[i] = r; ad[i] = a; wd[i] = d; sz[i] = s; sx[i] = x;
    tick();
    if (poke) begin
      dw[i] = 1'b1; dr[i] = 1'b0; wd[i] = 32'd0; sz[i] = 2'b10;
    end else begin
      cs[i] = 1'b0;
    end
    got = 1'b0;
    for (int n = 1; n <= 40 && !got; n++) begin
      tick();
      if (n == 1) cs[i] = 1'b0;
      if (rdy[i]) begin
        got = 1'b1;
        check($sformatf("u%0d_latency@%h", i, a), 32'(n), 32'(lat));
        check($sformatf("u%0d_misalign@%h", i, a), 32'(mis[i]), 32'(emis));
        if (chk) check($sformatf("u%0d_rdata_lit@%h", i, a), rd[i], erd);
      end
    end
    check($sformatf("u%0d_completed@%h", i, a), 32'(got), 32'd1);
  endtask

  initial begin
    int first;
    int second;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; cs[i] = 1'b0; dw[i] = 1'b0; dr[i] = 1'b0;
      sx[i] = 1'b0; ad[i] = 32'd0; wd[i] = 32'd0; sz[i] = 2'b10;
    end
    repeat (2) tick();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    tick();

    // Zero wait states: sizes, lanes, extension.
    req(0, 1, 0, 32'h100, 32'h1122_3344, 2'b10, 0, 0, 1, 0, 0, 32'd0);
    req(0, 0, 1, 32'h100, 32'd0,         2'b10, 0, 0, 1, 0, 1, 32'h1122_3344);
    req(0, 1, 0, 32'h103, 32'h0000_00AB, 2'b00, 0, 0, 1, 0, 0, 32'd0);
    req(0, 0, 1, 32'h100, 32'd0,         2'b10, 0, 0, 1, 0, 1, 32'hAB22_3344);
    req(0, 0, 1, 32'h103, 32'd0,         2'b00, 1, 0, 1, 0, 1, 32'hFFFF_FFAB);
    req(0, 0, 1, 32'h103, 32'd0,         2'b00, 0, 0, 1, 0, 1, 32'h0000_00AB);
    req(0, 0, 1, 32'h102, 32'd0,         2'b01, 0, 0, 1, 0, 1, 32'h0000_AB22);
    req(0, 1, 0, 32'h100, 32'h0000_8001, 2'b01, 0, 0, 1, 0, 0, 32'd0);
    req(0, 0, 1, 32'h100, 32'd0,         2'b01, 1, 0, 1, 0, 1, 32'hFFFF_8001);
    // Misalignment.
    req(0, 0, 1, 32'h102, 32'd0,         2'b10, 0, 0, 1, 1, 1, 32'd0);
    req(0, 1, 0, 32'h101, 32'h0000_5555, 2'b01, 0, 0, 1, 1, 1, 32'd0);
    req(0, 0, 1, 32'h100, 32'd0,         2'b10, 0, 0, 1, 0, 1, 32'hAB22_8001);
    req(0, 0, 1, 32'h100, 32'd0,         2'b11, 0, 0, 1, 1, 1, 32'd0);
    // Address wrap and dual request.
    req(0, 1, 0, 32'h2000, 32'hCAFE_F00D, 2'b10, 0, 0, 1, 0, 0, 32'd0);
    req(0, 0, 1, 32'h0,    32'd0,         2'b10, 0, 0, 1, 0, 1, 32'hCAFE_F00D);
    req(0, 1, 1, 32'h4,    32'h1234_5678, 2'b10, 0, 0, 1, 0, 1, 32'hCAFE_F00D);
    req(0, 0, 1, 32'h4,    32'd0,         2'b10, 0, 0, 1, 0, 1, 32'h1234_5678);

    // Three wait states.
    req(1, 1, 0, 32'h100, 32'h55AA_00FF, 2'b10, 0, 0, 4, 0, 0, 32'd0);
    req(1, 0, 1, 32'h100, 32'd0,         2'b10, 0, 1, 4, 0, 1, 32'h55AA_00FF);
    req(1, 0, 1, 32'h100, 32'd0,         2'b10, 0, 0, 4, 0, 1, 32'h55AA_00FF);
    req(1, 0, 1, 32'h103, 32'd0,         2'b11, 0, 0, 1, 1, 1, 32'd0);
    req(1, 0, 1, 32'h100, 32'd0,         2'b10, 0, 0, 4, 0, 1, 32'h55AA_00FF);

    // Request held through ready: re-accepted at the first idle edge.
    cs[1] = 1'b1; dw[1] = 1'b0; dr[1] = 1'b1; ad[1] = 32'h100; sz[1] = 2'b10;
    tick();
    first  = 0;
    second = 0;
    for (int n = 1; n <= 20 && second == 0; n++) begin
      tick();
      if (rdy[1]) begin
        if (first == 0) first = n;
        else begin
          second = n;
          cs[1]  = 1'b0;
        end
      end
    end
    cs[1] = 1'b0;
    check("u1_held_first_ready", 32'(first), 32'd4);
    check("u1_held_second_ready", 32'(second), 32'd9);

    // Reset in the middle of a wait-stated store.
    req(1, 1, 0, 32'h200, 32'd0, 2'b10, 0, 0, 4, 0, 0, 32'd0);
    cs[1] = 1'b1; dw[1] = 1'b1; dr[1] = 1'b0; ad[1] = 32'h200; wd[1] = 32'hDEAD_BEEF;
    tick();
    cs[1] = 1'b0;
    tick();
    check("u1_busy_before_rst", 32'(bsy[1]), 32'd1);
    rst_n[1] = 1'b0;
    #1;
    check("u1_async_rst_busy", 32'(bsy[1]), 32'd0);
    check("u1_async_rst_ready", 32'(rdy[1]), 32'd0);
    check("u1_async_rst_mis", 32'(mis[1]), 32'd0);
    check("u1_async_rst_rdata", rd[1], 32'd0);
    repeat (2) tick();
    rst_n[1] = 1'b1;
    tick();
    req(1, 0, 1, 32'h200, 32'd0, 2'b10, 0, 0, 4, 0, 1, 32'd0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
